// File: rtl/if_mux_pkg.sv
// Shared constants and types for the channel mux/arbiter master.
package if_mux_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    MODE_DIRECTED = 1'b0,
    MODE_RR       = 1'b1
  } mode_e;

endpackage

// File: rtl/if_mux_skid.sv
// Two-entry FIFO feeding the registered output; head is the word on the output.
module if_mux_skid
  import if_mux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         valid
);

  logic [W-1:0] tail;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count == 2'(BUF_DEPTH));
  assign valid   = (count != 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  // Simultaneous push/pop only happens at count=1: the new word replaces the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: head <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/if_mux_arb_master.sv
// NUM_CH-input mux master: directed or round-robin grant into a 2-entry output buffer.
module if_mux_arb_master
  import if_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data [NUM_CH],
  input  logic [NUM_CH-1:0]     i_valid,
  output logic [NUM_CH-1:0]     o_ready,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [SEL_W-1:0]      o_y_ch,
  output logic                  o_y_valid,
  input  logic                  i_y_ready
);

  typedef struct packed {
    logic [SEL_W-1:0]      ch;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic [1:0]       count;
  logic             full;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;
  int               idx;

  // Descending scan so the last hit, i.e. the smallest offset from rr_ptr, wins.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    idx      = 0;
    if (mode_e'(i_mode) == MODE_DIRECTED) begin
      grant    = i_sel;
      grant_ok = ({1'b0, i_sel} < (SEL_W + 1)'(NUM_CH));
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (i_valid[idx]) begin
          grant    = SEL_W'(idx);
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Ready depends only on the registered fill level, never on i_y_ready.
  always_comb begin
    o_ready = '0;
    if (!i_rst && grant_ok && !full) o_ready[grant] = 1'b1;
  end

  assign push            = |(i_valid & o_ready);
  assign pop             = o_y_valid && i_y_ready;
  assign push_entry.ch   = grant;
  assign push_entry.data = i_data[grant];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (mode_e'(i_mode) == MODE_RR && push) begin
      rr_ptr <= SEL_W'((int'(grant) + 1) % NUM_CH);
    end
  end

  if_mux_skid #(
    .W($bits(entry_t))
  ) u_skid (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .valid    (o_y_valid)
  );

  assign o_y    = head.data;
  assign o_y_ch = head.ch;

endmodule

// File: tb/tb_if_mux_arb_master.sv
// Directed and random stimulus against a queue-based reference model of the mux master.
module tb_if_mux_arb_master;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int SW  = 2;
  localparam int EW  = SW + DW;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  data [NCH];
  logic [NCH-1:0] valid;
  logic [NCH-1:0] ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [DW-1:0]  y;
  logic [SW-1:0]  y_ch;
  logic           y_valid;
  logic           y_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected output words in order, plus the round-robin pointer.
  logic [EW-1:0] exp_q[$];
  int            m_ptr = 0;

  always #5 clk = ~clk;

  if_mux_arb_master #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (data),
    .i_valid  (valid),
    .o_ready  (ready),
    .i_mode   (mode),
    .i_sel    (sel),
    .o_y      (y),
    .o_y_ch   (y_ch),
    .o_y_valid(y_valid),
    .i_y_ready(y_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic m, input logic [SW-1:0] s,
                                     input logic [NCH-1:0] v);
    if (!m) return (int'(s) < NCH) ? int'(s) : -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic step(input logic m, input logic [SW-1:0] s, input logic [NCH-1:0] v,
                      input logic yr, input logic [31:0] d);
    int             g;
    logic [NCH-1:0] exp_ready;
    logic           acc;
    @(negedge clk);
    mode    = m;
    sel     = s;
    valid   = v;
    y_ready = yr;
    for (int i = 0; i < NCH; i++) data[i] = d[8*i +: 8];
    #1;
    g         = model_grant(m, s, v);
    exp_ready = (g >= 0 && exp_q.size() < 2) ? (NCH'(1) << g) : '0;
    acc       = (exp_ready != '0) && v[g];
    chk("o_ready", 32'(ready), 32'(exp_ready));
    chk("o_y_valid", 32'(y_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("o_y", 32'(y), 32'(exp_q[0][DW-1:0]));
      chk("o_y_ch", 32'(y_ch), 32'(exp_q[0][EW-1:DW]));
    end
    @(posedge clk);
    if (exp_q.size() > 0 && yr) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({SW'(g), d[8*g +: 8]});
      if (m) m_ptr = (g + 1) % NCH;
    end
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 1'b1;
    sel     = '0;
    valid   = 4'hF;
    y_ready = 1'b0;
    for (int i = 0; i < NCH; i++) data[i] = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_y_ch", 32'(y_ch), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Directed select of channel 2, one-cycle latency.
    step(1'b0, 2'd2, 4'b0100, 1'b1, 32'h00A5_0000);
    #1;
    chk("t1_y", 32'(y), 32'hA5);
    chk("t1_y_ch", 32'(y_ch), 32'd2);
    chk("t1_y_valid", 32'(y_valid), 32'd1);

    // Directed select of an idle channel: nothing moves.
    step(1'b0, 2'd1, 4'b0001, 1'b1, 32'h4433_2211);
    #1;
    chk("t2_y_valid", 32'(y_valid), 32'd0);

    // Round-robin with everyone valid: 0,1,2,3,0,1,2,3 at full rate.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 4'hF, 1'b1, 32'h1312_1110);
      #1;
      chk("t3_y_ch", 32'(y_ch), 32'(i % 4));
      chk("t3_y", 32'(y), 32'(8'h10 + i % 4));
    end
    step(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);

    // Back-pressure fills both entries, then drains in order.
    repeat (3) step(1'b1, 2'd0, 4'hF, 1'b0, 32'h2322_2120);
    chk("t4_full_ready", 32'(ready), 32'd0);
    repeat (4) step(1'b1, 2'd0, 4'hF, 1'b1, 32'h2322_2120);
    repeat (2) step(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);

    // Asynchronous reset between edges with a full buffer.
    repeat (2) step(1'b1, 2'd0, 4'hF, 1'b0, 32'h3332_3130);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_y_valid", 32'(y_valid), 32'd0);
    chk("t5_ready", 32'(ready), 32'd0);
    chk("t5_y", 32'(y), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'd0, 4'hF, 1'b1, 32'h4342_4140);
    #1;
    chk("t5_first_ch", 32'(y_ch), 32'd0);

    // Mode switch: pointer parked at 3 survives a directed interlude.
    step(1'b1, 2'd0, 4'b0100, 1'b1, 32'h5352_5150);
    step(1'b0, 2'd0, 4'hF, 1'b1, 32'h5352_5150);
    #1;
    chk("t6_dir_ch", 32'(y_ch), 32'd0);
    step(1'b1, 2'd0, 4'hF, 1'b1, 32'h5352_5150);
    #1;
    chk("t6_rr_ch", 32'(y_ch), 32'd3);

    // Random traffic with mixed modes, selects and back-pressure.
    repeat (400) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), $urandom);
    end
    repeat (3) step(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
